// File: rtl/alu_seq_unit.sv
// Request/response ALU with single-cycle add/sub/logic/compare ops and a
// shift-and-add multiply that takes one cycle per operand bit.
module alu_seq_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
  typedef enum logic [2:0] {OpAdd, OpSub, OpAnd, OpOr, OpNor, OpSlt, OpSltu, OpMul} op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;

  op_e              op;
  logic             legal, is_mul, accept, last_bit;
  logic [WIDTH-1:0] sum, diff, alu_res, acc_step;
  logic             alu_ovf;

  // Decode
  always_comb begin
    op    = OpAdd;
    legal = 1'b1;
    unique case (alu_op)
      2'b00: op = OpAdd;
      2'b01: op = OpSub;
      2'b10: begin
        case (funct)
          6'b100000: op = OpAdd;
          6'b100010: op = OpSub;
          6'b100100: op = OpAnd;
          6'b100101: op = OpOr;
          6'b100111: op = OpNor;
          6'b101010: op = OpSlt;
          6'b101011: op = OpSltu;
          6'b011000: begin
            op    = OpMul;
            legal = MUL_EN;
          end
          default: legal = 1'b0;
        endcase
      end
      2'b11: legal = 1'b0;
    endcase
  end

  assign is_mul   = legal && (op == OpMul);
  assign accept   = in_valid && (state_q == StIdle);
  assign last_bit = (cnt_q == CntW'(1));
  assign sum      = a + b;
  assign diff     = a - b;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res[0] = $signed(a) < $signed(b);
      OpSltu:  alu_res[0] = a < b;
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = is_mul ? StMul : StDone;
      StMul:  if (last_bit) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    result    = result_q;
    zero      = zero_q;
    ovf       = ovf_q;
    illegal   = illegal_q;
  end

  // Datapath next values; results only change on accept or the final multiply bit
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    if (accept) begin
      if (is_mul) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = CntW'(WIDTH);
      end else begin
        result_d  = legal ? alu_res : '0;
        zero_d    = legal ? (alu_res == '0) : 1'b1;
        ovf_d     = legal && alu_ovf;
        illegal_d = !legal;
      end
    end else if (state_q == StMul) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
      if (last_bit) begin
        result_d  = acc_step;
        zero_d    = (acc_step == '0);
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: a 32-bit instance plus 8-bit instances with and
// without the multiplier, checked through a result scoreboard.
module tb_alu_seq_unit;

  localparam logic [5:0] FnAdd = 6'b100000, FnSub = 6'b100010, FnAnd = 6'b100100;
  localparam logic [5:0] FnOr = 6'b100101, FnNor = 6'b100111, FnSlt = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011, FnMul = 6'b011000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [63:0] a = '0, b = '0;

  logic [2:0]  iv, ir, ov, zr, of, il, bz;
  logic [31:0] r0;
  logic [7:0]  r1, r2;

  logic        o_ir, o_ov, o_zr, o_of, o_il, o_bz;
  logic [63:0] o_res;

  for (genvar k = 0; k < 3; k++) begin : g_iv
    assign iv[k] = in_valid && (sel == k);
  end

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .alu_op(alu_op),
    .funct(funct), .a(a[31:0]), .b(b[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .result(r0), .zero(zr[0]), .ovf(of[0]), .illegal(il[0]), .busy(bz[0])
  );

  alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .alu_op(alu_op),
    .funct(funct), .a(a[7:0]), .b(b[7:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .result(r1), .zero(zr[1]), .ovf(of[1]), .illegal(il[1]), .busy(bz[1])
  );

  alu_seq_unit #(.WIDTH(8), .MUL_EN(1'b0)) u_w8_nomul (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .alu_op(alu_op),
    .funct(funct), .a(a[7:0]), .b(b[7:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .result(r2), .zero(zr[2]), .ovf(of[2]), .illegal(il[2]), .busy(bz[2])
  );

  always_comb begin
    case (sel)
      1:       o_res = {56'b0, r1};
      2:       o_res = {56'b0, r2};
      default: o_res = {32'b0, r0};
    endcase
    o_ir = ir[sel];
    o_ov = ov[sel];
    o_zr = zr[sel];
    o_of = of[sel];
    o_il = il[sel];
    o_bz = bz[sel];
  end

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        o;
    logic        il;
    int          lat;   // clock edges from accept to out_valid; -1 = not checked
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshaken output must match the oldest outstanding request
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && o_ov && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", o_res, e.v.res);
        chk("zero", {63'b0, o_zr}, {63'b0, e.v.z});
        chk("ovf", {63'b0, o_of}, {63'b0, e.v.o});
        chk("illegal", {63'b0, o_il}, {63'b0, e.v.il});
        if (e.v.lat >= 0) chk("latency", 64'(cyc - e.acc_cyc), 64'(e.v.lat));
      end
    end
  end

  // Called just after a falling edge; the request is accepted on the next rising edge
  task automatic drive(input vec_t v);
    sel      = v.sel;
    alu_op   = v.op;
    funct    = v.fn;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    sb.push_back('{v: v, acc_cyc: cyc + 1});
  endtask

  task automatic finish_req(input vec_t v);
    int n = 0;
    int bc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    while (sb.size() != 0 && n < 200) begin
      if (o_bz && !o_ir && !o_ov) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    if (v.lat >= 0) chk("busy_cycles", 64'(bc), 64'(v.lat));
    chk("valid_one_cycle", {63'b0, o_ov}, 64'd0);
    chk("ready_after", {63'b0, o_ir}, 64'd1);
  endtask

  vec_t tbl[20];
  vec_t bp, mr, ad;

  initial begin
    tbl[0]  = '{0, 2'b00, 6'h0,   64'd5,        64'd7,        64'd12,       0, 0, 0, 0};
    tbl[1]  = '{0, 2'b10, FnSub,  64'd3,        64'd5,        64'hFFFFFFFE, 0, 0, 0, 0};
    tbl[2]  = '{0, 2'b00, 6'h0,   64'h7FFFFFFF, 64'd1,        64'h80000000, 0, 1, 0, 0};
    tbl[3]  = '{0, 2'b10, FnSlt,  64'hFFFFFFFF, 64'd1,        64'd1,        0, 0, 0, 0};
    tbl[4]  = '{0, 2'b10, FnSltu, 64'hFFFFFFFF, 64'd1,        64'd0,        1, 0, 0, 0};
    tbl[5]  = '{0, 2'b10, FnMul,  64'd1234,     64'd10,       64'd12340,    0, 0, 0, 32};
    tbl[6]  = '{0, 2'b10, FnMul,  64'h10000,    64'h10000,    64'd0,        1, 0, 0, 32};
    tbl[7]  = '{0, 2'b11, 6'h0,   64'd9,        64'd9,        64'd0,        1, 0, 1, 0};
    tbl[8]  = '{0, 2'b01, 6'h0,   64'h80000000, 64'd1,        64'h7FFFFFFF, 0, 1, 0, 0};
    tbl[9]  = '{0, 2'b10, FnAnd,  64'hF0F0,     64'hFF00,     64'hF000,     0, 0, 0, 0};
    tbl[10] = '{0, 2'b10, FnOr,   64'hF0F0,     64'hFF00,     64'hFFF0,     0, 0, 0, 0};
    tbl[11] = '{0, 2'b10, FnNor,  64'd0,        64'd0,        64'hFFFFFFFF, 0, 0, 0, 0};
    tbl[12] = '{0, 2'b10, FnMul,  64'd99,       64'd0,        64'd0,        1, 0, 0, 32};
    tbl[13] = '{0, 2'b10, 6'h00,  64'd1,        64'd2,        64'd0,        1, 0, 1, 0};
    tbl[14] = '{0, 2'b10, FnAdd,  64'hFFFFFFFF, 64'd1,        64'd0,        1, 0, 0, 0};
    tbl[15] = '{1, 2'b10, FnMul,  64'd15,       64'd17,       64'hFF,       0, 0, 0, 8};
    tbl[16] = '{2, 2'b10, FnMul,  64'd15,       64'd17,       64'd0,        1, 0, 1, 0};
    tbl[17] = '{1, 2'b00, 6'h0,   64'h7F,       64'd1,        64'h80,       0, 1, 0, 0};
    tbl[18] = '{0, 2'b01, 6'h0,   64'd5,        64'd5,        64'd0,        1, 0, 0, 0};
    tbl[19] = '{1, 2'b10, FnMul,  64'hFF,       64'hFF,       64'h01,       0, 0, 0, 8};
    bp = '{0, 2'b11, 6'h0,  64'd1,    64'd1,  64'd0,  1, 0, 1, -1};
    mr = '{0, 2'b10, FnMul, 64'd1234, 64'd10, 64'd0,  0, 0, 0, -1};
    ad = '{0, 2'b00, 6'h0,  64'd20,   64'd22, 64'd42, 0, 0, 0, 0};

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {63'b0, o_ir}, 64'd1);
    chk("rst_out_valid", {63'b0, o_ov}, 64'd0);
    chk("rst_busy", {63'b0, o_bz}, 64'd0);
    chk("rst_result", o_res, 64'd0);
    chk("rst_flags", {61'b0, o_zr, o_of, o_il}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      finish_req(tbl[i]);
    end

    // Backpressure: outputs hold and in_valid is ignored while DONE waits
    @(negedge clk);
    out_ready = 1'b0;
    drive(bp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_valid", {63'b0, o_ov}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_op   = 2'b00;
      a        = 64'd5;
      b        = 64'd7;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'b0, o_ov}, 64'd1);
      chk("bp_hold_result", o_res, 64'd0);
      chk("bp_hold_flags", {61'b0, o_zr, o_of, o_il}, 64'b101);
      chk("bp_in_ready", {63'b0, o_ir}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_valid", {63'b0, o_ov}, 64'd0);
    chk("bp_idle_ready", {63'b0, o_ir}, 64'd1);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Reset during a multiply, then accept on the first edge after release
    @(negedge clk);
    drive(mr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mrst_valid", {63'b0, o_ov}, 64'd0);
    chk("mrst_busy", {63'b0, o_bz}, 64'd0);
    chk("mrst_ready", {63'b0, o_ir}, 64'd1);
    chk("mrst_result", o_res, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst_hold_valid", {63'b0, o_ov}, 64'd0);
    end
    reset = 1'b0;
    drive(ad);
    finish_req(ad);

    // Aborted multiply must not surface later
    repeat (40) @(negedge clk);
    chk("no_late_output", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width; the legal range is 4 to 64.
REQ-002 Parameter MUL_EN, default 1: when 1, the iterative multiply is enabled; when 0, the multiply funct is treated as illegal.
REQ-003 clk  input  1  Single clock; all state changes on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 in_valid  input  1  The request fields below are valid this cycle.
REQ-006 in_ready  output  1  The unit can accept a request this cycle.
REQ-007 alu_op  input  2  Operation class: 00 = add, 01 = sub, 10 = R-type (decode funct), 11 = reserved.
REQ-008 funct  input  6  R-type function field, used only when alu_op=10.
REQ-009 a, b  input  WIDTH each  Operands.
REQ-010 out_valid  output  1  result and the flags are valid.
REQ-011 out_ready  input  1  The consumer accepts the output this cycle.
REQ-012 result  output  WIDTH  Operation result.
REQ-013 zero  output  1  High when result equals 0.
REQ-014 ovf  output  1  Signed overflow; meaningful for add and sub only, 0 for all other operations.
REQ-015 illegal  output  1  The completed request was an undefined encoding.
REQ-016 busy  output  1  High when the state is not IDLE.

Function
REQ-017 The decode SHALL be:
- alu_op 00 = add; alu_op 01 = sub.
- alu_op 10 with funct 100000 = add, 100010 = sub, 100100 = and, 100101 = or, 100111 = nor, 101010 = slt (signed), 101011 = sltu, 011000 = mul (low WIDTH bits).
- Any other encoding = illegal.
REQ-018 The FSM SHALL have three states: IDLE, MUL and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid and in_ready are both 1.
REQ-020 For a single-cycle operation or an illegal encoding, the accept edge SHALL register result and the flags and move IDLE to DONE, so out_valid is 1 in the next cycle (latency 1).
REQ-021 For mul, the accept edge SHALL load the multiplicand, the multiplier, a zero accumulator and a counter of WIDTH, then move IDLE to MUL.
REQ-022 Each MUL cycle SHALL add the multiplicand to the accumulator when the multiplier LSB is 1, shift the multiplicand left, shift the multiplier right and decrement the counter.
REQ-023 The MUL-to-DONE transition SHALL occur on the edge that processes the final bit, so out_valid rises WIDTH cycles after the accept edge.
REQ-024 In DONE, result, zero, ovf and illegal SHALL hold stable until out_ready=1; the edge with out_valid=1 and out_ready=1 SHALL return to IDLE.
REQ-025 Throughput SHALL be at most one single-cycle request every 2 cycles; there is no overlap between DONE and acceptance of a new request.
REQ-026 in_valid SHALL be ignored outside IDLE, and the input fields are sampled only on the accept edge.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH.
- slt and sltu produce {WIDTH-1 zeros, bit}.
- ovf for add = (a and b have equal signs) and (the result sign differs from them).
- ovf for sub = (a and b have differing signs) and (the result sign differs from a).
REQ-028 An illegal request SHALL give result=0, zero=1, ovf=0 and illegal=1.
REQ-029 Multiplying by b=0 SHALL still take the full WIDTH cycles; there is no early termination.
REQ-030 When MUL_EN=0, funct 011000 SHALL be illegal with latency 1.
REQ-031 When out_ready=1 is already high on DONE entry, the next edge SHALL return to IDLE, so out_valid is high for exactly 1 cycle.

Reset
REQ-032 Asserting reset SHALL immediately force state IDLE and clear all outputs and internal state:
- in_ready=1, out_valid=0, busy=0, result=0;
- zero=0, ovf=0, illegal=0;
- counter, accumulator and operand registers all 0.
REQ-033 Reset asserted in MUL or DONE SHALL abort the operation, with no output produced after reset deasserts.
REQ-034 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-035 Add and sub: alu_op=00 with a=5, b=7 -> one cycle later out_valid=1, result=12, zero=0, ovf=0. Then alu_op=10, funct=100010, a=3, b=5 -> result=0xFFFFFFFE.
REQ-036 Overflow and slt: add with a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1. slt with a=0xFFFFFFFF, b=1 -> result=1. sltu with the same operands -> result=0.
REQ-037 Multiply: funct=011000, a=1234, b=10 -> busy=1 and in_ready=0 for 32 cycles, out_valid rises exactly 32 cycles after the accept edge, result=12340. Also a=0x10000, b=0x10000 -> result=0, zero=1.
REQ-038 Illegal and backpressure: alu_op=11 -> illegal=1, result=0, zero=1. Hold out_ready=0 for 5 cycles -> outputs stable and in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-039 Reset mid-operation: assert reset at cycle 10 of a multiply -> outputs cleared immediately and out_valid stays 0 afterwards. A new add request on the first edge after reset deasserts completes normally.
REQ-040 Parameters: WIDTH=8, MUL_EN=1 with mul 15x17 -> result=0xFF after 8 cycles. MUL_EN=0 with the same request -> illegal=1 after 1 cycle.
